game_sequencer: RTL and testbench

//  Top-level flow controller for one round of play. Drives the mode and diff buses consumed by main_game.

---
 rtl/game_pkg.sv | 30 +++
 rtl/game_sequencer_if.sv | 30 +++
 rtl/game_sequencer_btn_edge.sv | 32 +++
 rtl/game_sequencer.sv | 163 ++++++++++++++++
 tb/tb_game_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
// The difficulty table maps diff_sel onto the main_game scroll divider limit.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        COUNTDOWN = 3'd2,
        PLAY      = 3'd3,
        PAUSE     = 3'd4,
        END       = 3'd5
    } mode_t;

    localparam logic [22:0] DIFF_EASY   = 23'd5_000_000;
    localparam logic [22:0] DIFF_MEDIUM = 23'd3_500_000;
    localparam logic [22:0] DIFF_HARD   = 23'd2_000_000;
    localparam logic [22:0] DIFF_INSANE = 23'd1_500_000;

    function automatic logic [22:0] diff_lookup(input logic [1:0] sel);
        logic [22:0] lim;
        unique case (sel)
            2'd0:    lim = DIFF_EASY;
            2'd1:    lim = DIFF_MEDIUM;
            2'd2:    lim = DIFF_HARD;
            default: lim = DIFF_INSANE;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the round sequencer and its environment.
// master drives the buttons and game pulses, slave is the sequencer.
interface game_sequencer_if;
    import game_pkg::*;

    logic        start_btn;
    logic        pause_btn;
    logic [1:0]  diff_sel;
    logic        beat_clk;
    logic        hit;
    logic        missed;

    mode_t       mode;
    logic [22:0] diff;
    logic [1:0]  countdown;
    logic [7:0]  beat_count;
    logic        game_over;
    logic        failed;

    modport master (
        output start_btn, pause_btn, diff_sel, beat_clk, hit, missed,
        input  mode, diff, countdown, beat_count, game_over, failed
    );

    modport slave (
        input  start_btn, pause_btn, diff_sel, beat_clk, hit, missed,
        output mode, diff, countdown, beat_count, game_over, failed
    );

endinterface

// File: rtl/game_sequencer_btn_edge.sv
// Button conditioner: two-flop synchroniser, rising-edge detect, registered pulse.
// A raw press yields a single-cycle pulse three cycles after the raw edge.
module seq_btn_edge (
    input  logic clk,
    input  logic n_rst,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;
    logic pulse_q;

    // Synchronise the raw button and register a one-cycle pulse on its rising edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            prev    <= sync2;
            pulse_q <= sync2 & ~prev;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/game_sequencer.sv
// Round flow controller: IDLE -> LOAD -> COUNTDOWN -> PLAY <-> PAUSE -> END.
// Optional feature macro: AUTO_FAIL_EN (miss-streak game over). Default build leaves it out.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 20_000_000,
    parameter int unsigned SONG_BEATS  = 64,
    parameter int unsigned TAIL_BEATS  = 39,
    parameter int unsigned FAIL_MISSES = 8
) (
    input logic             clk,
    input logic             n_rst,
    game_sequencer_if.slave bus
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    // Song length must fit the 8-bit beat counter for the round to end on beats.
    localparam logic [7:0] END_BEAT = 8'(SONG_BEATS + TAIL_BEATS);

    logic start_ev;
    logic pause_ev;

    seq_btn_edge u_start_edge (
        .clk   (clk),
        .n_rst (n_rst),
        .btn   (bus.start_btn),
        .pulse (start_ev)
    );

    seq_btn_edge u_pause_edge (
        .clk   (clk),
        .n_rst (n_rst),
        .btn   (bus.pause_btn),
        .pulse (pause_ev)
    );

    mode_t             mode_q;
    logic [22:0]       diff_q;
    logic [1:0]        countdown_q;
    logic [7:0]        beat_count_q;
    logic              game_over_q;
    logic              failed_q;
    logic [STEP_W-1:0] step_q;

    logic song_end;
    logic miss_limit;

    // This beat pulse brings the count to the full song length.
    assign song_end = bus.beat_clk && (beat_count_q != 8'hFF)
                      && ((beat_count_q + 8'd1) == END_BEAT);

`ifdef AUTO_FAIL_EN
    localparam int unsigned STREAK_W = $clog2(FAIL_MISSES + 1);

    logic [STREAK_W-1:0] streak_q;

    // A lone miss that completes the streak; a hit in the same cycle cancels it.
    assign miss_limit = (mode_q == PLAY) && bus.missed && !bus.hit
                        && (streak_q == STREAK_W'(FAIL_MISSES - 1));

    // Consecutive-miss counter, live only during PLAY, restarted at each LOAD.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            streak_q <= '0;
        end else if (mode_q == LOAD) begin
            streak_q <= '0;
        end else if (mode_q == PLAY) begin
            if (bus.hit) begin
                streak_q <= '0;
            end else if (bus.missed) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end
`else
    logic unused_game_pulses;

    assign miss_limit         = 1'b0;
    assign unused_game_pulses = bus.hit ^ bus.missed;
`endif

    // Round FSM with its step and beat counters; every output is registered here.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q       <= IDLE;
            diff_q       <= DIFF_EASY;
            countdown_q  <= 2'd0;
            beat_count_q <= 8'd0;
            game_over_q  <= 1'b0;
            failed_q     <= 1'b0;
            step_q       <= '0;
        end else begin
            unique case (mode_q)
                IDLE: begin
                    if (start_ev) begin
                        mode_q <= LOAD;
                    end
                end
                LOAD: begin
                    diff_q       <= diff_lookup(bus.diff_sel);
                    beat_count_q <= 8'd0;
                    failed_q     <= 1'b0;
                    countdown_q  <= 2'd3;
                    step_q       <= '0;
                    mode_q       <= COUNTDOWN;
                end
                COUNTDOWN: begin
                    if (step_q == STEP_LAST) begin
                        step_q      <= '0;
                        countdown_q <= countdown_q - 2'd1;
                        if (countdown_q == 2'd1) begin
                            mode_q <= PLAY;
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                PLAY: begin
                    if (bus.beat_clk && (beat_count_q != 8'hFF)) begin
                        beat_count_q <= beat_count_q + 8'd1;
                    end
                    // Miss-streak failure outranks song end when both land together.
                    if (miss_limit) begin
                        mode_q      <= END;
                        game_over_q <= 1'b1;
                        failed_q    <= 1'b1;
                    end else if (song_end) begin
                        mode_q      <= END;
                        game_over_q <= 1'b1;
                    end else if (pause_ev) begin
                        mode_q <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_ev) begin
                        mode_q <= IDLE;
                    end else if (pause_ev) begin
                        mode_q <= PLAY;
                    end
                end
                END: begin
                    if (start_ev) begin
                        mode_q      <= IDLE;
                        game_over_q <= 1'b0;
                        failed_q    <= 1'b0;
                    end
                end
                default: begin
                    mode_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mode       = mode_q;
    assign bus.diff       = diff_q;
    assign bus.countdown  = countdown_q;
    assign bus.beat_count = beat_count_q;
    assign bus.game_over  = game_over_q;
    assign bus.failed     = failed_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a cycle-level behavioural model of one round of play,
// compared against the DUT every cycle, plus literal checks of key moments.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int unsigned STEP  = 4;
    localparam int unsigned SONG  = 8;
    localparam int unsigned TAIL  = 2;
    localparam int unsigned FAILN = 3;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    game_sequencer_if bus ();

    game_sequencer #(
        .STEP_CYCLES (STEP),
        .SONG_BEATS  (SONG),
        .TAIL_BEATS  (TAIL),
        .FAIL_MISSES (FAILN)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned tbl [4] = '{5_000_000, 3_500_000, 2_000_000, 1_500_000};

    mode_t       m_mode;
    int unsigned m_diff;
    int unsigned m_left;   // cycles of countdown remaining
    int unsigned m_beats;  // unsaturated beats in this round
    int unsigned m_streak;
    bit          m_over;
    bit          m_failed;
    logic [3:0]  s_hist;   // raw start samples, newest in bit 0
    logic [3:0]  p_hist;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_mode   <= IDLE;
            m_diff   <= tbl[0];
            m_left   <= 0;
            m_beats  <= 0;
            m_streak <= 0;
            m_over   <= 1'b0;
            m_failed <= 1'b0;
            s_hist   <= '0;
            p_hist   <= '0;
        end else begin : model_step
            mode_t       nm;
            int unsigned nd, nl, nb, ns;
            bit          no, nf, sev, pev, af;
            nm = m_mode; nd = m_diff; nl = m_left; nb = m_beats; ns = m_streak;
            no = m_over; nf = m_failed;
`ifdef AUTO_FAIL_EN
            af = 1'b1;
`else
            af = 1'b0;
`endif
            // Button seen rising three samples ago is the event acted on now.
            sev = s_hist[2] & ~s_hist[3];
            pev = p_hist[2] & ~p_hist[3];
            case (m_mode)
                IDLE: if (sev) nm = LOAD;
                LOAD: begin
                    nd = tbl[bus.diff_sel];
                    nb = 0; ns = 0; nf = 1'b0;
                    nl = 3 * STEP;
                    nm = COUNTDOWN;
                end
                COUNTDOWN: begin
                    nl = nl - 1;
                    if (nl == 0) nm = PLAY;
                end
                PLAY: begin
                    if (bus.beat_clk) nb = nb + 1;
                    if (af && bus.hit) ns = 0;
                    else if (af && bus.missed) ns = ns + 1;
                    if (af && ns == FAILN) begin
                        nm = END; no = 1'b1; nf = 1'b1;
                    end else if (bus.beat_clk && nb == SONG + TAIL) begin
                        nm = END; no = 1'b1;
                    end else if (pev) begin
                        nm = PAUSE;
                    end
                end
                PAUSE: begin
                    if (sev) nm = IDLE;
                    else if (pev) nm = PLAY;
                end
                END: if (sev) begin
                    nm = IDLE; no = 1'b0; nf = 1'b0;
                end
                default: nm = IDLE;
            endcase
            m_mode <= nm; m_diff <= nd; m_left <= nl; m_beats <= nb; m_streak <= ns;
            m_over <= no; m_failed <= nf;
            s_hist <= {s_hist[2:0], bus.start_btn};
            p_hist <= {p_hist[2:0], bus.pause_btn};
        end
    end

    // Compare every cycle, a little after the active edge and clear of stimulus.
    always begin
        @(posedge clk);
        #3;
        if (chk_en && n_rst) begin
            chk("model_mode", 32'(bus.mode), 32'(m_mode));
            chk("model_diff", 32'(bus.diff), m_diff);
            chk("model_countdown", 32'(bus.countdown), (m_left + STEP - 1) / STEP);
            chk("model_beat_count", 32'(bus.beat_count), (m_beats > 255) ? 255 : m_beats);
            chk("model_game_over", 32'(bus.game_over), 32'(m_over));
            chk("model_failed", 32'(bus.failed), 32'(m_failed));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 start, 1 pause, 2 both in the same cycle
    task automatic press(input int which);
        bus.start_btn = (which != 1);
        bus.pause_btn = (which != 0);
        tick(1);
        bus.start_btn = 1'b0;
        bus.pause_btn = 1'b0;
    endtask

    task automatic beats(input int n);
        repeat (n) begin
            bus.beat_clk = 1'b1;
            tick(1);
            bus.beat_clk = 1'b0;
            tick(1);
        end
    endtask

    task automatic game_pulse(input logic h, input logic m);
        bus.hit    = h;
        bus.missed = m;
        tick(1);
        bus.hit    = 1'b0;
        bus.missed = 1'b0;
        tick(1);
    endtask

    task automatic wait_mode(input mode_t target, input int budget);
        int k = 0;
        while (bus.mode !== target && k < budget) begin
            tick(1);
            k++;
        end
        chk("wait_mode", 32'(bus.mode), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start_btn = 1'b0;
        bus.pause_btn = 1'b0;
        bus.diff_sel  = 2'd2;
        bus.beat_clk  = 1'b0;
        bus.hit       = 1'b0;
        bus.missed    = 1'b0;

        // Reset values
        tick(2);
        chk("rst_mode", 32'(bus.mode), 32'(IDLE));
        chk("rst_diff", 32'(bus.diff), 32'd5_000_000);
        chk("rst_countdown", 32'(bus.countdown), 32'd0);
        chk("rst_beat_count", 32'(bus.beat_count), 32'd0);
        chk("rst_game_over", 32'(bus.game_over), 32'd0);
        chk("rst_failed", 32'(bus.failed), 32'd0);
        n_rst  = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // Round 1: exact start latency, countdown cadence, song end
        press(0);
        tick(3);
        chk("load_mode", 32'(bus.mode), 32'(LOAD));
        tick(1);
        chk("cd_mode", 32'(bus.mode), 32'(COUNTDOWN));
        chk("cd_3", 32'(bus.countdown), 32'd3);
        chk("diff_hard", 32'(bus.diff), 32'd2_000_000);
        bus.diff_sel = 2'd0;            // no effect outside LOAD
        press(1);                       // ignored during countdown
        tick(3);
        chk("cd_2", 32'(bus.countdown), 32'd2);
        tick(4);
        chk("cd_1", 32'(bus.countdown), 32'd1);
        chk("cd1_mode", 32'(bus.mode), 32'(COUNTDOWN));
        tick(4);
        chk("play_mode", 32'(bus.mode), 32'(PLAY));
        chk("cd_0", 32'(bus.countdown), 32'd0);
        chk("diff_kept", 32'(bus.diff), 32'd2_000_000);
        press(0);                       // dropped in PLAY
        tick(4);
        chk("start_dropped", 32'(bus.mode), 32'(PLAY));
        beats(10);
        chk("end_beats", 32'(bus.beat_count), 32'd10);
        chk("end_mode", 32'(bus.mode), 32'(END));
        chk("end_game_over", 32'(bus.game_over), 32'd1);
        press(0);
        tick(3);
        chk("idle_after_end", 32'(bus.mode), 32'(IDLE));
        chk("idle_game_over", 32'(bus.game_over), 32'd0);

        // Round 2: pause freezes beats
        bus.diff_sel = 2'd3;
        press(0);
        wait_mode(PLAY, 40);
        chk("diff_insane", 32'(bus.diff), 32'd1_500_000);
        beats(4);
        press(1);
        wait_mode(PAUSE, 10);
        beats(5);
        chk("pause_hold", 32'(bus.beat_count), 32'd4);
        press(1);
        wait_mode(PLAY, 10);
        beats(6);
        chk("end2_mode", 32'(bus.mode), 32'(END));
        chk("end2_beats", 32'(bus.beat_count), 32'd10);
        press(0);
        wait_mode(IDLE, 10);

        // Round 3: simultaneous start and pause in PAUSE aborts
        press(0);
        wait_mode(PLAY, 40);
        press(1);
        wait_mode(PAUSE, 10);
        press(2);
        tick(3);
        chk("abort_idle", 32'(bus.mode), 32'(IDLE));

        // Round 4: miss streak
        press(0);
        wait_mode(PLAY, 40);
`ifdef AUTO_FAIL_EN
        game_pulse(1'b0, 1'b1);
        game_pulse(1'b0, 1'b1);
        game_pulse(1'b1, 1'b1);         // hit+miss together clears the streak
        game_pulse(1'b0, 1'b1);
        game_pulse(1'b0, 1'b1);
        chk("streak_cleared", 32'(bus.mode), 32'(PLAY));
        game_pulse(1'b1, 1'b0);
        game_pulse(1'b0, 1'b1);
        game_pulse(1'b0, 1'b1);
        game_pulse(1'b1, 1'b0);
        game_pulse(1'b0, 1'b1);
        game_pulse(1'b0, 1'b1);
        chk("two_misses_play", 32'(bus.mode), 32'(PLAY));
        chk("two_misses_failed", 32'(bus.failed), 32'd0);
        game_pulse(1'b0, 1'b1);
        chk("fail_mode", 32'(bus.mode), 32'(END));
        chk("fail_flag", 32'(bus.failed), 32'd1);
        chk("fail_game_over", 32'(bus.game_over), 32'd1);
        press(0);
        wait_mode(IDLE, 10);
        chk("fail_cleared", 32'(bus.failed), 32'd0);
`else
        repeat (5) game_pulse(1'b0, 1'b1);
        chk("no_autofail_mode", 32'(bus.mode), 32'(PLAY));
        chk("no_autofail_flag", 32'(bus.failed), 32'd0);
        beats(10);
        chk("no_autofail_end", 32'(bus.mode), 32'(END));
        chk("no_autofail_end_flag", 32'(bus.failed), 32'd0);
        press(0);
        wait_mode(IDLE, 10);
`endif

        // Round 5: asynchronous reset mid-countdown
        press(0);
        wait_mode(COUNTDOWN, 20);
        tick(5);
        n_rst = 1'b0;
        #1;
        chk("arst_mode", 32'(bus.mode), 32'(IDLE));
        chk("arst_diff", 32'(bus.diff), 32'd5_000_000);
        chk("arst_countdown", 32'(bus.countdown), 32'd0);
        chk("arst_beat_count", 32'(bus.beat_count), 32'd0);
        chk("arst_game_over", 32'(bus.game_over), 32'd0);
        chk("arst_failed", 32'(bus.failed), 32'd0);
        tick(2);
        n_rst = 1'b1;
        tick(1);
        press(0);
        wait_mode(COUNTDOWN, 20);
        chk("rearm_cd_3", 32'(bus.countdown), 32'd3);
        tick(4);
        chk("rearm_cd_2", 32'(bus.countdown), 32'd2);
        wait_mode(PLAY, 20);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
